mac_array_param: RTL and testbench

Parametrised successor of the layer-1 MAC array: N_NEURONS parallel signed MACs share one streamed input sample per beat, each with its own weight. Adds a job-level FSM, valid/ready input and output handshakes, a 2-stage multiply/accumulate pipeline, saturating accumulation, and a requantise/ReLU output stage.
Sits between the weight/pixel fetch logic and the next layer's input buffer. Used for any dense layer, not only layer 1.

---
 rtl/mac_pkg.sv | 60 ++++++
 rtl/mac_lane.sv | 66 ++++++
 rtl/mac_array_param.sv | 131 +++++++++++++
 tb/tb_mac_array_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared state encoding, default widths and saturating arithmetic helpers
// for the parametrised MAC array and its lanes.
package mac_pkg;

    localparam int DEF_N_NEURONS  = 32;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ACC_W      = 20;
    localparam int DEF_LEN_W      = 10;
    localparam int DEF_BIAS_SHIFT = 8;
    localparam int DEF_OUT_SHIFT  = 8;

    // Helpers compute at a fixed wide width so any lane width up to 62 bits
    // can be summed and shifted without intermediate overflow.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    function automatic wide_t max_of(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t min_of(input int w);
        return -max_of(w) - wide_t'(1);
    endfunction

    function automatic logic out_of_range(input wide_t x, input int w);
        return (x > max_of(w)) || (x < min_of(w));
    endfunction

    function automatic wide_t clamp(input wide_t x, input int w);
        if (x > max_of(w)) begin
            return max_of(w);
        end
        if (x < min_of(w)) begin
            return min_of(w);
        end
        return x;
    endfunction

    function automatic wide_t sat_add(input wide_t acc, input wide_t prod, input int acc_w);
        return clamp(acc + prod, acc_w);
    endfunction

    function automatic wide_t requant(input wide_t acc, input int shift, input logic relu,
                                      input int data_w);
        wide_t t;
        t = clamp(acc >>> shift, data_w);
        if (relu && (t < 0)) begin
            t = '0;
        end
        return t;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered product, saturating accumulate with bias preload,
// and a combinational requantise/ReLU view of the accumulator.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_preload,
    input  logic signed [DATA_W-1:0] i_bias,
    input  logic                     i_beat,
    input  logic signed [DATA_W-1:0] i_pixel,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic                     i_relu,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic signed [DATA_W-1:0] o_act,
    output logic                     o_sat
);

    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_prod_valid;
    logic signed [ACC_W-1:0]    r_acc;

    wide_t w_preload_wide;
    wide_t w_sum_wide;
    logic  w_preload_sat;
    logic  w_add_sat;

    always_comb begin
        w_preload_wide = wide_t'(i_bias) <<< BIAS_SHIFT;
        w_sum_wide     = wide_t'(r_acc) + wide_t'(r_prod);
        w_preload_sat  = out_of_range(w_preload_wide, ACC_W);
        w_add_sat      = out_of_range(w_sum_wide, ACC_W);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and the two stages stay one cycle apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the product stage is reset as well as the accumulator, so a
            // job aborted mid-stream cannot leak a stale product into the next one.
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_prod_valid <= i_beat;
            if (i_beat) begin
                r_prod <= i_pixel * i_weight;
            end
            if (i_preload) begin
                r_acc <= ACC_W'(clamp(w_preload_wide, ACC_W));
            end else if (r_prod_valid) begin
                r_acc <= ACC_W'(sat_add(wide_t'(r_acc), wide_t'(r_prod), ACC_W));
            end
        end
    end

    assign o_sat = i_preload ? w_preload_sat : (r_prod_valid && w_add_sat);
    assign o_acc = r_acc;
    assign o_act = DATA_W'(requant(wide_t'(r_acc), OUT_SHIFT, i_relu, DATA_W));

endmodule

// File: rtl/mac_array_param.sv
// Job-level control for N_NEURONS parallel MAC lanes sharing one streamed
// sample per beat; valid/ready on both sides, sticky saturation flag.
module mac_array_param
    import mac_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    input  logic                          relu_en,
    input  logic [N_NEURONS*DATA_W-1:0]   biases_packed,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      pixel,
    input  logic [N_NEURONS*DATA_W-1:0]   weights_packed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*ACC_W-1:0]    acc_out_packed,
    output logic [N_NEURONS*DATA_W-1:0]   act_out_packed,
    output logic                          sat_flag,
    output logic                          busy
);

    state_t r_state;
    state_t w_state_next;

    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic                 r_relu;
    logic                 r_sat;
    logic                 r_drain_tick;
    logic                 w_start;
    logic                 w_beat;
    logic                 w_last_beat;
    logic [N_NEURONS-1:0] w_lane_sat;

    assign w_start     = start && (r_state == IDLE);
    assign w_beat      = in_valid && (r_state == ACCUM);
    assign w_last_beat = w_beat && ((r_cnt + LEN_W'(1)) == r_len);

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (w_last_beat) begin
                    w_state_next = DRAIN;
                end
            end
            // Two cycles: the last product registers, then the final add commits.
            DRAIN: begin
                if (r_drain_tick) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_relu       <= 1'b0;
            r_sat        <= 1'b0;
            r_drain_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drain_tick <= (r_state == DRAIN) && !r_drain_tick;
            if (w_start) begin
                r_len  <= len;
                r_relu <= relu_en;
                r_cnt  <= '0;
                r_sat  <= |w_lane_sat;
            end else begin
                if (w_beat) begin
                    r_cnt <= r_cnt + LEN_W'(1);
                end
                if (|w_lane_sat) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_lane
        mac_lane #(
            .DATA_W    (DATA_W),
            .ACC_W     (ACC_W),
            .BIAS_SHIFT(BIAS_SHIFT),
            .OUT_SHIFT (OUT_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_preload(w_start),
            .i_bias   (biases_packed[j*DATA_W +: DATA_W]),
            .i_beat   (w_beat),
            .i_pixel  (pixel),
            .i_weight (weights_packed[j*DATA_W +: DATA_W]),
            .i_relu   (r_relu),
            .o_acc    (acc_out_packed[j*ACC_W +: ACC_W]),
            .o_act    (act_out_packed[j*DATA_W +: DATA_W]),
            .o_sat    (w_lane_sat[j])
        );
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_mac_array_param.sv
// Randomised bench for mac_array_param: jobs push model results into a
// scoreboard that a separate monitor pops on every output handshake.
module tb_mac_array_param;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int LW   = 10;
    localparam int BS   = 8;
    localparam int OS   = 8;
    localparam int MAXB = 64;

    typedef struct packed {
        logic [N*AW-1:0] acc;
        logic [N*DW-1:0] act;
        logic            sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [LW-1:0]        len_i = '0;
    logic                 relu_en = 1'b0;
    logic [N*DW-1:0]      biases_packed = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] pixel = '0;
    logic [N*DW-1:0]      weights_packed = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [N*AW-1:0]      acc_out_packed;
    logic [N*DW-1:0]      act_out_packed;
    logic                 sat_flag;
    logic                 busy;

    int   j_bias [N];
    int   j_pix  [MAXB];
    int   j_w    [MAXB][N];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mac_array_param #(
        .N_NEURONS (N),
        .DATA_W    (DW),
        .ACC_W     (AW),
        .LEN_W     (LW),
        .BIAS_SHIFT(BS),
        .OUT_SHIFT (OS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len_i),
        .relu_en       (relu_en),
        .biases_packed (biases_packed),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pixel         (pixel),
        .weights_packed(weights_packed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .acc_out_packed(acc_out_packed),
        .act_out_packed(act_out_packed),
        .sat_flag      (sat_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: integer arithmetic straight from the layer rules.
    function automatic exp_t model(input int n, input bit relu);
        exp_t   e;
        longint hi, lo, a, t;
        e     = '0;
        hi    = (longint'(1) << (AW - 1)) - 1;
        lo    = -hi - 1;
        for (int j = 0; j < N; j++) begin
            a = longint'(j_bias[j]) * (longint'(1) << BS);
            if (a > hi) begin a = hi; e.sat = 1'b1; end
            if (a < lo) begin a = lo; e.sat = 1'b1; end
            for (int b = 0; b < n; b++) begin
                a = a + longint'(j_pix[b]) * longint'(j_w[b][j]);
                if (a > hi) begin a = hi; e.sat = 1'b1; end
                if (a < lo) begin a = lo; e.sat = 1'b1; end
            end
            t = a >>> OS;
            if (t > 127)  t = 127;
            if (t < -128) t = -128;
            if (relu && t < 0) t = 0;
            e.acc[j*AW +: AW] = a[AW-1:0];
            e.act[j*DW +: DW] = t[DW-1:0];
        end
        return e;
    endfunction

    task automatic drive_biases();
        for (int j = 0; j < N; j++) biases_packed[j*DW +: DW] = DW'(j_bias[j]);
    endtask

    task automatic drive_weights(input int b);
        for (int j = 0; j < N; j++) weights_packed[j*DW +: DW] = DW'(j_w[b][j]);
    endtask

    task automatic fill(input int n, input int pix, input int w);
        for (int b = 0; b < n; b++) begin
            j_pix[b] = pix;
            for (int j = 0; j < N; j++) j_w[b][j] = w;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got a result, expected none queued");
            end else begin
                e = sb.pop_front();
                check("mon_acc", acc_out_packed, e.acc);
                check("mon_act", act_out_packed, e.act);
                check("mon_sat", sat_flag, e.sat);
            end
        end
    end

    task automatic run_job(input int n, input bit relu, input bit rnd, input int stall,
                           input bit busy_start, input string tag);
        exp_t e;
        int   k;
        int   budget;
        bit   go;
        bit   saw_ready;
        e = model(n, relu);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; len_i = LW'(n); relu_en = relu; drive_biases();
        @(posedge clk); #1;
        start = 1'b0; k = cyc;
        // Scramble start-time inputs: none of them may be re-sampled.
        len_i = LW'($urandom); relu_en = ~relu; biases_packed = $urandom;
        for (int b = 0; b < n; b++) begin
            budget = 200; go = 1'b0;
            while (!go && budget > 0) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (in_valid) begin
                    pixel = DW'(j_pix[b]); drive_weights(b);
                end else begin
                    pixel = DW'($urandom); weights_packed = $urandom;
                end
                start = busy_start && (b == n / 2);
                @(negedge clk);
                go = in_valid && in_ready;
                @(posedge clk); #1;
                start = 1'b0; budget--;
            end
            check({tag, "_beat_accept"}, 128'(go), 128'(1));
            k = cyc;
        end
        in_valid = 1'b1; pixel = DW'($urandom); weights_packed = $urandom;
        budget = 20; go = 1'b0; saw_ready = 1'b0;
        while (!go && budget > 0) begin
            @(negedge clk);
            saw_ready = saw_ready | in_ready;
            go = out_valid;
            if (!go) begin
                @(posedge clk); #1; budget--;
            end
        end
        check({tag, "_latency"}, 128'(cyc - k), 128'(2));
        check({tag, "_no_extra_beat"}, 128'(saw_ready), 128'(0));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_hold"}, {out_valid, acc_out_packed, act_out_packed},
                  {1'b1, e.acc, e.act});
        end
        @(posedge clk); #1;
        budget = 50; go = 1'b0;
        while (!go && budget > 0) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = busy_start && out_ready;
            go = out_ready;
            @(posedge clk); #1;
            budget--;
        end
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after_accept"}, {busy, out_valid, in_ready}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {busy, in_ready, out_valid, sat_flag}, 0);
        check("reset_acc", acc_out_packed, 0);
        check("reset_act", act_out_packed, 0);

        // Basic job, then the same job under random valid and output stalls.
        j_bias = '{1, 0, -1, 2};
        j_pix[0] = 2; j_pix[1] = 3; j_pix[2] = -1;
        for (int b = 0; b < 3; b++) for (int j = 0; j < N; j++) j_w[b][j] = 1;
        run_job(3, 1'b0, 1'b0, 0, 1'b0, "basic");
        run_job(3, 1'b0, 1'b1, 5, 1'b0, "backpressure");

        // Negative saturation with and without ReLU, then positive saturation.
        j_bias = '{0, 0, 0, 0};
        fill(40, -128, 127);
        run_job(40, 1'b1, 1'b0, 0, 1'b0, "sat_neg_relu");
        run_job(40, 1'b0, 1'b0, 0, 1'b0, "sat_neg");
        fill(40, -128, -128);
        run_job(40, 1'b0, 1'b0, 0, 1'b0, "sat_pos");

        // Zero-length job: bias-only result.
        j_bias = '{5, -3, 0, 127};
        run_job(0, 1'b0, 1'b0, 2, 1'b0, "len0");

        // Abort after two beats; nothing may be emitted and state must clear.
        j_bias = '{-7, 9, 100, -100};
        fill(5, 77, -90);
        @(posedge clk); #1;
        start = 1'b1; len_i = LW'(5); relu_en = 1'b0; drive_biases();
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; pixel = DW'(j_pix[b]); drive_weights(b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {busy, in_ready, out_valid, sat_flag}, 0);
        check("abort_acc", acc_out_packed, 0);
        check("abort_act", act_out_packed, 0);
        run_job(5, 1'b0, 1'b0, 0, 1'b0, "after_abort");

        // Start pulses during ACCUM and during the DONE handshake are ignored.
        j_bias = '{12, -12, 33, -1};
        fill(6, -50, 61);
        run_job(6, 1'b1, 1'b0, 0, 1'b1, "busy_start");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int j = 0; j < N; j++) j_bias[j] = $urandom_range(0, 255) - 128;
            for (int b = 0; b < n; b++) begin
                j_pix[b] = $urandom_range(0, 255) - 128;
                for (int j = 0; j < N; j++) j_w[b][j] = $urandom_range(0, 255) - 128;
            end
            run_job(n, 1'($urandom_range(0, 1)), 1'b1, (r % 2) * 3, 1'(r == 5), "random");
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
